// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/PAUSE program-counter stepper fed by an external next-address adder
module pc_sequencer #(
    parameter int          WIDTH    = 6,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] pc,
    output logic             running,
    output logic             wrapped,
    output logic [7:0]       adv_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t           state, state_next;
    logic             advance, wrap_next;
    logic [WIDTH-1:0] pc_next;
    logic [7:0]       cnt_next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    // Stop wins over start in RUN; a PAUSE with both high keeps waiting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = stop ? PAUSE : RUN;
            PAUSE:   state_next = (start && !stop) ? RUN : PAUSE;
            default: state_next = IDLE;
        endcase
    end
    // The stopping edge still takes sum and counts; only load suppresses an advance.
    always_comb begin
        advance   = (state == RUN) && !load;
        pc_next   = load ? load_val : (advance ? sum : pc);
        wrap_next = advance && (sum < pc);
        cnt_next  = (advance && adv_cnt != 8'hff) ? adv_cnt + 8'd1 : adv_cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= WIDTH'(RESET_PC);
            running <= 1'b0;
            wrapped <= 1'b0;
            adv_cnt <= 8'd0;
        end else begin
            pc      <= pc_next;
            running <= (state_next == RUN);
            wrapped <= wrap_next;
            adv_cnt <= cnt_next;
        end
    end
endmodule
